pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen_pkg.sv | 27 ++
 rtl/pattern_gen_if.sv | 30 +++
 rtl/pattern_gen_tick_div.sv | 37 +++
 rtl/pattern_gen.sv | 147 ++++++++++++++
 tb/tb_pattern_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared types for the pattern generator.
//   state_e - FSM states (IDLE, RUN, DONE)
//   mode_e  - sequence-select encodings as seen on the mode input
//   to_gray - binary to reflected-Gray conversion (up to MAX_WIDTH bits)
package pattern_gen_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_BIN_UP   = 2'b00,
        MODE_BIN_DOWN = 2'b01,
        MODE_GRAY_UP  = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    // Reflected Gray code: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [MAX_WIDTH-1:0] to_gray(input logic [MAX_WIDTH-1:0] v);
        return v ^ (v >> 4'd1);
    endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// pattern_gen_if: control and stimulus-output bundle of pattern_gen.
//   start/stop/mode/oneshot/seed : commands into the generator
//   pattern/valid/busy/done/wrap : generator outputs
// master = the controller issuing commands, slave = the generator.
interface pattern_gen_if #(
    parameter int WIDTH = 3
) ();

    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic             oneshot;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] pattern;
    logic             valid;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output start, stop, mode, oneshot, seed,
        input  pattern, valid, busy, done, wrap
    );

    modport slave (
        input  start, stop, mode, oneshot, seed,
        output pattern, valid, busy, done, wrap
    );

endinterface

// File: rtl/pattern_gen_tick_div.sv
// tick_div: prescaler for pattern_gen. Counts 0..PERIOD-1 while en is high
// and flags the last count with tick; clr restarts the count at 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart of the count
//   en         : count enable
//   tick       : high during the cycle the count sits at PERIOD-1 (and en)
module tick_div #(
    parameter int PERIOD = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // PERIOD is at most 255, so an 8-bit counter always suffices.
    localparam logic [7:0] LAST = 8'(PERIOD - 1);

    logic [7:0] cnt_r;

    assign tick = en && (cnt_r == LAST);

    // Prescaler count register; wraps to 0 on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= tick ? 8'd0 : (cnt_r + 8'd1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: sweeps a WIDTH-bit index in binary up/down or Gray-up order,
// stepping once every PERIOD clocks, either once (oneshot) or continuously.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : begin a sweep (IDLE/DONE only)   bus.stop : abort a sweep
//   bus.mode/oneshot/seed : sweep settings, captured at start
//   bus.pattern: registered stimulus vector       bus.valid: new-pattern strobe
//   bus.busy   : in RUN    bus.done : in DONE     bus.wrap : continuous wrap strobe
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int PERIOD = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    pattern_gen_if.slave    bus
);

    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] LAST_W = {WIDTH{1'b1}};

    state_e           state_r,   state_next_s;
    mode_e            mode_r,    mode_next_s;
    logic             oneshot_r, oneshot_next_s;
    logic [WIDTH-1:0] index_r,   index_next_s;
    logic [WIDTH-1:0] step_r,    step_next_s;
    logic [WIDTH-1:0] pattern_r, pattern_next_s;
    logic             valid_r,   valid_next_s;
    logic             wrap_r,    wrap_next_s;
    logic             busy_r;
    logic             done_r;
    logic             presc_clr_s;
    logic             presc_en_s;
    logic             tick_s;
    logic [WIDTH-1:0] index_step_s;

    // Map an index to the presented pattern for the captured mode.
    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] idx, input mode_e m);
        logic [WIDTH-1:0] res;
        case (m)
            MODE_GRAY_UP: res = WIDTH'(to_gray(MAX_WIDTH'(idx)));
            default:      res = idx;
        endcase
        return res;
    endfunction

    assign presc_en_s   = (state_r == RUN);
    assign index_step_s = (mode_r == MODE_BIN_DOWN) ? (index_r - ONE_W) : (index_r + ONE_W);

    tick_div #(
        .PERIOD (PERIOD)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr_s),
        .en    (presc_en_s),
        .tick  (tick_s)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_next_s   = state_r;
        mode_next_s    = mode_r;
        oneshot_next_s = oneshot_r;
        index_next_s   = index_r;
        step_next_s    = step_r;
        pattern_next_s = pattern_r;
        valid_next_s   = 1'b0;
        wrap_next_s    = 1'b0;
        presc_clr_s    = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                // stop wins over a simultaneous start
                if (bus.start && !bus.stop) begin
                    state_next_s   = RUN;
                    mode_next_s    = (bus.mode == MODE_RSVD) ? MODE_BIN_UP : mode_e'(bus.mode);
                    oneshot_next_s = bus.oneshot;
                    index_next_s   = bus.seed;
                    step_next_s    = '0;
                    pattern_next_s = encode(bus.seed, mode_next_s);
                    valid_next_s   = 1'b1;
                    presc_clr_s    = 1'b1;
                end else begin
                    state_next_s   = state_r;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_next_s = IDLE;
                    presc_clr_s  = 1'b1;
                end else if (tick_s) begin
                    // step_r counts steps since start; all-ones means the
                    // next step lands back on the seed.
                    if (oneshot_r && (step_r == LAST_W)) begin
                        state_next_s = DONE;
                    end else begin
                        index_next_s   = index_step_s;
                        step_next_s    = step_r + ONE_W;
                        pattern_next_s = encode(index_step_s, mode_r);
                        valid_next_s   = 1'b1;
                        wrap_next_s    = !oneshot_r && (step_r == LAST_W);
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, captured settings and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mode_r    <= MODE_BIN_UP;
            oneshot_r <= 1'b0;
            index_r   <= '0;
            step_r    <= '0;
            pattern_r <= '0;
            valid_r   <= 1'b0;
            wrap_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            mode_r    <= mode_next_s;
            oneshot_r <= oneshot_next_s;
            index_r   <= index_next_s;
            step_r    <= step_next_s;
            pattern_r <= pattern_next_s;
            valid_r   <= valid_next_s;
            wrap_r    <= wrap_next_s;
            busy_r    <= (state_next_s == RUN);
            done_r    <= (state_next_s == DONE);
        end
    end

    assign bus.pattern = pattern_r;
    assign bus.valid   = valid_r;
    assign bus.wrap    = wrap_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: scoreboard bench for pattern_gen. Three instances cover
// (W3,P5), (W3,P1) and (W4,P2). Stimulus pushes hand-computed {wrap,pattern}
// expectations into per-instance queues; negedge monitors pop and compare on valid.
module tb_pattern_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    logic [16:0] e0, e1, e2;
    logic [2:0]  prev1;
    bit          have1 = 1'b0;

    pattern_gen_if #(.WIDTH(3)) b0 ();
    pattern_gen_if #(.WIDTH(3)) b1 ();
    pattern_gen_if #(.WIDTH(4)) b2 ();

    pattern_gen #(.WIDTH(3), .PERIOD(5)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pattern_gen #(.WIDTH(3), .PERIOD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pattern_gen #(.WIDTH(4), .PERIOD(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input int pat);
        checks++;
        errors++;
        $display("FAIL %s: got valid with pattern %0d, expected no valid", name, pat);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: one per instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (b0.valid) begin
            if (q0.size() == 0) extra("u0_extra_valid", int'(b0.pattern));
            else begin
                e0 = q0.pop_front();
                chk("u0_wrap_pattern", int'({b0.wrap, 13'd0, b0.pattern}), int'(e0));
            end
        end else chk("u0_wrap_idle", int'(b0.wrap), 0);
    end

    always @(negedge clk) begin
        if (b1.valid) begin
            if (q1.size() == 0) extra("u1_extra_valid", int'(b1.pattern));
            else begin
                e1 = q1.pop_front();
                chk("u1_wrap_pattern", int'({b1.wrap, 13'd0, b1.pattern}), int'(e1));
            end
            if (have1) chk("u1_gray_one_bit", $countones(prev1 ^ b1.pattern), 1);
            prev1 = b1.pattern;
            have1 = 1'b1;
        end else chk("u1_wrap_idle", int'(b1.wrap), 0);
    end

    always @(negedge clk) begin
        if (b2.valid) begin
            if (q2.size() == 0) extra("u2_extra_valid", int'(b2.pattern));
            else begin
                e2 = q2.pop_front();
                chk("u2_wrap_pattern", int'({b2.wrap, 12'd0, b2.pattern}), int'(e2));
            end
        end else chk("u2_wrap_idle", int'(b2.wrap), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v;
        rst_n = 1'b0;
        {b0.start, b0.stop, b0.mode, b0.oneshot, b0.seed} = '0;
        {b1.start, b1.stop, b1.mode, b1.oneshot, b1.seed} = '0;
        {b2.start, b2.stop, b2.mode, b2.oneshot, b2.seed} = '0;
        cyc(3);
        chk("rst_pattern", int'(b0.pattern), 0);
        chk("rst_valid",   int'(b0.valid), 0);
        chk("rst_busy",    int'(b0.busy), 0);
        chk("rst_done",    int'(b0.done), 0);
        chk("rst_u2_pattern", int'(b2.pattern), 0);
        rst_n = 1'b1;
        cyc(2);

        // Binary-up oneshot, PERIOD 5: 0..7, done after 40 clocks, hold 7.
        for (int k = 0; k < 8; k++) q0.push_back(17'(k));
        b0.mode = 2'b00; b0.oneshot = 1'b1; b0.seed = 3'd0; b0.start = 1'b1;
        cyc(1);
        b0.start = 1'b0;
        chk("a_busy_after_start", int'(b0.busy), 1);
        n = 0;
        while (!b0.done && n < 100) begin cyc(1); n++; end
        chk("a_cycles_to_done", n, 40);
        chk("a_done", int'(b0.done), 1);
        chk("a_busy_in_done", int'(b0.busy), 0);
        cyc(6);
        chk("a_pattern_held", int'(b0.pattern), 7);
        chk("a_queue_empty", q0.size(), 0);

        // Restart from DONE with seed 5; settings changed mid-run are ignored.
        for (int k = 0; k < 8; k++) q0.push_back(17'((5 + k) % 8));
        b0.mode = 2'b00; b0.oneshot = 1'b1; b0.seed = 3'd5; b0.start = 1'b1;
        cyc(1);
        b0.start = 1'b0;
        chk("d_done_cleared", int'(b0.done), 0);
        chk("d_busy", int'(b0.busy), 1);
        b0.mode = 2'b01; b0.seed = 3'd2; b0.oneshot = 1'b0; b0.start = 1'b1;
        cyc(1);
        b0.start = 1'b0;
        n = 1;
        while (!b0.done && n < 100) begin cyc(1); n++; end
        chk("d_cycles_to_done", n, 40);
        chk("d_pattern_held", int'(b0.pattern), 4);

        // Continuous binary up; start+stop together while showing pattern 2.
        for (int k = 0; k < 3; k++) q0.push_back(17'(k));
        b0.mode = 2'b00; b0.oneshot = 1'b0; b0.seed = 3'd0; b0.start = 1'b1;
        cyc(1);
        b0.start = 1'b0;
        cyc(10);
        chk("c_pattern_before_stop", int'(b0.pattern), 2);
        b0.start = 1'b1; b0.stop = 1'b1;
        cyc(1);
        b0.start = 1'b0; b0.stop = 1'b0;
        chk("c_busy_after_stop", int'(b0.busy), 0);
        chk("c_done_after_stop", int'(b0.done), 0);
        chk("c_pattern_held", int'(b0.pattern), 2);
        cyc(20);
        chk("c_queue_empty", q0.size(), 0);

        // Gray-up oneshot, PERIOD 1.
        q1.push_back(17'd0); q1.push_back(17'd1); q1.push_back(17'd3); q1.push_back(17'd2);
        q1.push_back(17'd6); q1.push_back(17'd7); q1.push_back(17'd5); q1.push_back(17'd4);
        b1.mode = 2'b10; b1.oneshot = 1'b1; b1.seed = 3'd0; b1.start = 1'b1;
        cyc(1);
        b1.start = 1'b0;
        n = 0;
        while (!b1.done && n < 50) begin cyc(1); n++; end
        chk("b_cycles_to_done", n, 8);
        chk("b_pattern_held", int'(b1.pattern), 4);
        chk("b_queue_empty", q1.size(), 0);

        // Binary-down continuous, W4 P2, seed 3: wrap on second 3.
        for (int k = 0; k < 18; k++) begin
            v = (3 - k) & 15;
            q2.push_back({(k == 16), 16'(v)});
        end
        b2.mode = 2'b01; b2.oneshot = 1'b0; b2.seed = 4'd3; b2.start = 1'b1;
        cyc(1);
        b2.start = 1'b0;
        cyc(34);
        chk("e_pattern_k17", int'(b2.pattern), 2);
        chk("e_never_done", int'(b2.done), 0);
        b2.stop = 1'b1;
        cyc(1);
        b2.stop = 1'b0;
        chk("e_busy_after_stop", int'(b2.busy), 0);
        chk("e_pattern_held", int'(b2.pattern), 2);
        cyc(10);
        chk("e_queue_empty", q2.size(), 0);

        // Mid-sweep reset (mode 11 behaves as binary up), seed 1.
        q0.push_back(17'd1); q0.push_back(17'd2);
        b0.mode = 2'b11; b0.oneshot = 1'b0; b0.seed = 3'd1; b0.start = 1'b1;
        cyc(1);
        b0.start = 1'b0;
        cyc(7);
        chk("r_pattern_before_reset", int'(b0.pattern), 2);
        rst_n = 1'b0;
        #1;
        chk("r_pattern", int'(b0.pattern), 0);
        chk("r_valid",   int'(b0.valid), 0);
        chk("r_busy",    int'(b0.busy), 0);
        chk("r_done",    int'(b0.done), 0);
        chk("r_wrap",    int'(b0.wrap), 0);
        chk("r_u1_done", int'(b1.done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(20);
        chk("r_busy_after_release", int'(b0.busy), 0);
        chk("r_queue_empty", q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
